// File: rtl/mister_rom_loader.sv
// -----------------------------------------------------------------------------
// mister_rom_loader
//
// Streams ROM_LEN bytes from a handshaked byte source into a MiSTer-style ioctl
// download port. Each byte is fetched (src_req/src_ack), then written with a
// one-cycle ioctl_wr strobe. Consecutive strobes are spaced by a programmable
// gap, and the SDRAM loader may stretch that gap with ioctl_wait. The core is
// held in reset (rst) for the whole transfer plus RST_HOLD cycles, after which
// done is raised until the next start.
//
// Parameters
//   AW        address width of src_addr / ioctl_addr
//   ROM_LEN   number of bytes to transfer (0 allowed: reset pulse only)
//   WR_GAP    cycles between ioctl_wr rising edges with a one-cycle source (2..255)
//   RST_HOLD  cycles rst stays high after the last write
//
// Ports
//   clk50        in   system clock, rising edge
//   rst_base     in   asynchronous active-high reset
//   start        in   one-cycle download request (honoured in IDLE/DONE only)
//   src_req      out  byte fetch request
//   src_addr     out  byte address being fetched
//   src_ack      in   fetch strobe, src_data valid in the same cycle
//   src_data     in   fetched byte
//   ioctl_wait   in   loader back-pressure, holds off the next fetch
//   ioctl_wr     out  one-cycle write strobe
//   ioctl_addr   out  write address (valid with ioctl_wr)
//   ioctl_data   out  write data (valid with ioctl_wr)
//   downloading  out  high while the transfer is in progress
//   rst          out  core reset, low only in DONE
//   done         out  transfer and reset hold complete
// -----------------------------------------------------------------------------
module mister_rom_loader #(
    parameter int AW       = 25,
    parameter int ROM_LEN  = 1024,
    parameter int WR_GAP   = 8,
    parameter int RST_HOLD = 16
) (
    input  logic          clk50,
    input  logic          rst_base,
    input  logic          start,
    output logic          src_req,
    output logic [AW-1:0] src_addr,
    input  logic          src_ack,
    input  logic [7:0]    src_data,
    input  logic          ioctl_wait,
    output logic          ioctl_wr,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_data,
    output logic          downloading,
    output logic          rst,
    output logic          done
);

    // One shared down-counter times both the inter-write gap and the reset hold.
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int TW     = (HOLD_W > 8) ? HOLD_W : 8;

    // The gap is WRITE (1) + GAP (WR_GAP-2) + FETCH (1) cycles. The counter is
    // loaded on leaving WRITE with the number of GAP cycles still to go after
    // the first one, so it reaches zero in the last GAP cycle.
    localparam logic [TW-1:0] GAP_LOAD  = TW'((WR_GAP > 2) ? WR_GAP - 3 : 0);
    localparam logic [TW-1:0] HOLD_LOAD = TW'((RST_HOLD > 1) ? RST_HOLD - 1 : 0);
    localparam logic [AW-1:0] LAST_N    = AW'((ROM_LEN > 0) ? ROM_LEN - 1 : 0);
    localparam bit            NO_GAP    = (WR_GAP <= 2);
    localparam bit            EMPTY     = (ROM_LEN == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_GAP,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   n_q, n_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            src_req_q, src_req_d;
    logic [AW-1:0]   src_addr_q, src_addr_d;
    logic            ioctl_wr_q, ioctl_wr_d;
    logic [AW-1:0]   ioctl_addr_q, ioctl_addr_d;
    logic [7:0]      ioctl_data_q, ioctl_data_d;
    logic            downloading_q, downloading_d;
    logic            rst_q, rst_d;
    logic            done_q, done_d;
    logic            gap_end;

    always_ff @(posedge clk50 or posedge rst_base) begin
        if (rst_base) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            timer_q       <= '0;
            src_req_q     <= 1'b0;
            src_addr_q    <= '0;
            ioctl_wr_q    <= 1'b0;
            ioctl_addr_q  <= '0;
            ioctl_data_q  <= '0;
            downloading_q <= 1'b0;
            rst_q         <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            timer_q       <= timer_d;
            src_req_q     <= src_req_d;
            src_addr_q    <= src_addr_d;
            ioctl_wr_q    <= ioctl_wr_d;
            ioctl_addr_q  <= ioctl_addr_d;
            ioctl_data_q  <= ioctl_data_d;
            downloading_q <= downloading_d;
            rst_q         <= rst_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        timer_d       = timer_q;
        src_addr_d    = src_addr_q;
        ioctl_addr_d  = ioctl_addr_q;
        ioctl_data_d  = ioctl_data_q;
        downloading_d = downloading_q;
        gap_end       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d           = '0;
                    src_addr_d    = '0;
                    downloading_d = 1'b1;
                    if (EMPTY) begin
                        state_d = S_HOLD;
                        timer_d = HOLD_LOAD;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // The byte is captured straight into the output register, so
                // ioctl_data only ever changes on entry to WRITE.
                if (src_ack) begin
                    ioctl_data_d = src_data;
                    ioctl_addr_d = n_q;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                timer_d = GAP_LOAD;
                if (NO_GAP) begin
                    gap_end = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    gap_end = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_HOLD: begin
                // Also ends the one-cycle downloading pulse of an empty ROM.
                downloading_d = 1'b0;
                if (timer_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Gap expiry: the last byte finishes regardless of ioctl_wait; any
        // other byte waits here (counter parked at zero) until the loader is ready.
        if (gap_end) begin
            if (n_q == LAST_N) begin
                downloading_d = 1'b0;
                state_d       = S_HOLD;
                timer_d       = HOLD_LOAD;
            end else if (!ioctl_wait) begin
                n_d        = n_q + 1'b1;
                src_addr_d = n_q + 1'b1;
                state_d    = S_FETCH;
            end else begin
                state_d = S_GAP;
            end
        end

        // Strobes and status follow the state being entered, so every output
        // is a plain register that lines up with its state.
        src_req_d  = (state_d == S_FETCH);
        ioctl_wr_d = (state_d == S_WRITE);
        rst_d      = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    assign src_req     = src_req_q;
    assign src_addr    = src_addr_q;
    assign ioctl_wr    = ioctl_wr_q;
    assign ioctl_addr  = ioctl_addr_q;
    assign ioctl_data  = ioctl_data_q;
    assign downloading = downloading_q;
    assign rst         = rst_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mister_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_mister_rom_loader
//
// Randomised bench for mister_rom_loader. A byte source with per-address ack
// latency and optional stray acks, plus a random/forced ioctl_wait driver,
// feed the main instance (ROM_LEN=4). Each download pushes its expected writes
// into a queue; a negedge monitor pops one entry per ioctl_wr and checks
// address, data and the cycle it should occur on (derived from the gap rules
// and the recorded ioctl_wait history), plus downloading/done timing. A second
// instance with ROM_LEN=0 covers the empty download.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mister_rom_loader;

    localparam int AW       = 25;
    localparam int ROM_LEN  = 4;
    localparam int WR_GAP   = 8;
    localparam int RST_HOLD = 16;

    logic          clk50 = 1'b0;
    logic          rst_base = 1'b1;
    logic          start = 1'b0;
    logic          src_ack = 1'b0;
    logic [7:0]    src_data = 8'h00;
    logic          ioctl_wait = 1'b0;
    logic          src_req, ioctl_wr, downloading, rst, done;
    logic [AW-1:0] src_addr, ioctl_addr;
    logic [7:0]    ioctl_data;

    logic          start_z = 1'b0;
    logic          src_req_z, ioctl_wr_z, downloading_z, rst_z, done_z;
    logic [AW-1:0] src_addr_z, ioctl_addr_z;
    logic [7:0]    ioctl_data_z;

    always #5 clk50 = ~clk50;

    mister_rom_loader #(.AW(AW), .ROM_LEN(ROM_LEN), .WR_GAP(WR_GAP), .RST_HOLD(RST_HOLD)) dut (
        .clk50(clk50), .rst_base(rst_base), .start(start),
        .src_req(src_req), .src_addr(src_addr), .src_ack(src_ack), .src_data(src_data),
        .ioctl_wait(ioctl_wait), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .downloading(downloading), .rst(rst), .done(done)
    );

    mister_rom_loader #(.AW(AW), .ROM_LEN(0), .WR_GAP(WR_GAP), .RST_HOLD(RST_HOLD)) dut_z (
        .clk50(clk50), .rst_base(rst_base), .start(start_z),
        .src_req(src_req_z), .src_addr(src_addr_z), .src_ack(1'b0), .src_data(8'h00),
        .ioctl_wait(1'b0), .ioctl_wr(ioctl_wr_z), .ioctl_addr(ioctl_addr_z),
        .ioctl_data(ioctl_data_z), .downloading(downloading_z), .rst(rst_z), .done(done_z)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    function automatic void chk_ok(bit ok, string name, longint act, longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    // ---------------- byte source model ----------------
    logic [7:0] src_mem [0:ROM_LEN-1];
    int         delay_tbl [0:ROM_LEN-1];
    bit         stray_en = 1'b0;
    int         req_cnt = 0;

    // Acks on the d-th cycle src_req is seen high; garbage data otherwise.
    always @(posedge clk50) begin
        int a;
        #1;
        src_ack  = 1'b0;
        src_data = 8'($urandom);
        a = int'(src_addr);
        if (src_req) begin
            req_cnt++;
            if (a < ROM_LEN && req_cnt == delay_tbl[a]) begin
                src_ack  = 1'b1;
                src_data = src_mem[a];
            end
        end else begin
            req_cnt = 0;
            if (stray_en && $urandom_range(0, 3) == 0) src_ack = 1'b1;
        end
    end

    // ---------------- ioctl_wait driver ----------------
    bit wait_rand  = 1'b0;
    int wait_force = 0;

    always @(posedge clk50) begin
        #1;
        if (wait_force > 0) begin
            ioctl_wait = 1'b1;
            wait_force--;
        end else begin
            ioctl_wait = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int addr;
        int data;
        int d;
        bit first;
        bit last;
        int start_cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   wait_hist [0:32767];
    int   prev_wr      = 0;
    int   exp_dl_fall  = -1;
    int   exp_done     = -1;
    int   chk_start_at = -1;
    int   wr_count     = 0;
    logic prev_wr_o = 1'b0, prev_dl = 1'b0, prev_done = 1'b0, prev_done_z = 1'b0;

    int z_start = -1, z_dl_cycles = 0, z_wr = 0, z_req = 0, z_done_seen = 0;

    always @(negedge clk50) begin
        exp_t e;
        int   c;
        int   exp_cyc;
        if (cyc < 32768) wait_hist[cyc] = ioctl_wait;
        if (rst_base) begin
            chk("reset_values",
                {src_req, ioctl_wr, downloading, done, rst, ioctl_addr, ioctl_data, src_addr},
                longint'(1) << 58);
        end else begin
            if (ioctl_wr) begin
                wr_count++;
                chk("wr_not_back_to_back", prev_wr_o, 0);
                chk_ok(exp_q.size() != 0, "write_expected", ioctl_addr, -1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("write_addr[%0d]", e.addr), ioctl_addr, e.addr);
                    chk($sformatf("write_data[%0d]", e.addr), ioctl_data, e.data);
                    if (e.first) begin
                        exp_cyc = e.start_cyc + e.d + 1;
                    end else begin
                        // Gap expires in its last cycle, then waits for ioctl_wait low;
                        // fetch takes d cycles and the write follows.
                        c = prev_wr + WR_GAP - 2;
                        while (c < cyc && wait_hist[c]) c++;
                        exp_cyc = c + e.d + 1;
                    end
                    chk($sformatf("write_cycle[%0d]", e.addr), cyc, exp_cyc);
                    prev_wr = cyc;
                    if (e.last) begin
                        exp_dl_fall = cyc + WR_GAP - 1;
                        exp_done    = exp_dl_fall + RST_HOLD;
                    end
                end
            end
            if (prev_dl && !downloading) chk("downloading_fall_cycle", cyc, exp_dl_fall);
            if (!prev_done && done) begin
                chk("done_rise_cycle", cyc, exp_done);
                chk("rst_low_at_done", rst, 0);
            end
            if (cyc == chk_start_at) chk("start_accept_dl_rst_done", {downloading, rst, done}, 3'b110);

            if (downloading_z) z_dl_cycles++;
            if (ioctl_wr_z) z_wr++;
            if (src_req_z) z_req++;
            if (!prev_done_z && done_z) begin
                z_done_seen++;
                chk("z_done_rise_cycle", cyc, z_start + 1 + RST_HOLD);
                chk("z_rst_low_at_done", rst_z, 0);
            end
        end
        prev_wr_o   = ioctl_wr;
        prev_dl     = downloading;
        prev_done   = done;
        prev_done_z = done_z;
    end

    // ---------------- stimulus ----------------
    task automatic start_run();
        exp_t e;
        for (int a = 0; a < ROM_LEN; a++) src_mem[a] = 8'($urandom);
        @(posedge clk50); #1;
        start = 1'b1;
        for (int a = 0; a < ROM_LEN; a++) begin
            e.addr      = a;
            e.data      = int'(src_mem[a]);
            e.d         = delay_tbl[a];
            e.first     = (a == 0);
            e.last      = (a == ROM_LEN - 1);
            e.start_cyc = cyc;
            exp_q.push_back(e);
        end
        chk_start_at = cyc + 1;
        @(posedge clk50); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int t = 0;
        while (done !== 1'b1 && t < 3000) begin
            @(posedge clk50); #1;
            t++;
        end
        chk_ok(done === 1'b1, {"done_reached_", name}, t, 3000);
    endtask

    task automatic wait_writes(int target, string name);
        int t = 0;
        while (wr_count < target && t < 2000) begin
            @(negedge clk50); #1;
            t++;
        end
        chk_ok(wr_count >= target, {"writes_reached_", name}, wr_count, target);
    endtask

    task automatic set_delays(bit rnd);
        for (int a = 0; a < ROM_LEN; a++) delay_tbl[a] = rnd ? int'($urandom_range(1, 4)) : 1;
    endtask

    initial begin
        int base;
        int t;
        set_delays(1'b0);
        for (int a = 0; a < ROM_LEN; a++) src_mem[a] = 8'h00;

        repeat (3) @(posedge clk50);
        @(negedge clk50) rst_base = 1'b0;
        @(posedge clk50); #1;

        // Empty ROM instance
        z_start = cyc;
        start_z = 1'b1;
        @(posedge clk50); #1;
        start_z = 1'b0;

        // Clean download, one-cycle source, no back-pressure
        start_run();
        wait_done("clean");

        // Slow ack on byte 1, stray acks, ignored start during FETCH, restart from DONE
        delay_tbl[1] = 5;
        stray_en = 1'b1;
        start_run();
        t = 0;
        while (!(src_req && src_addr == 1) && t < 200) begin
            @(posedge clk50); #1;
            t++;
        end
        chk_ok(t < 200, "fetch_byte1_seen", t, 200);
        start = 1'b1;
        @(posedge clk50); #1;
        start = 1'b0;
        wait_done("slow_ack");

        chk("z_downloading_cycles", z_dl_cycles, 1);
        chk("z_writes", z_wr, 0);
        chk("z_src_req_cycles", z_req, 0);
        chk("z_done_seen", z_done_seen, 1);
        chk("z_outputs_idle", {ioctl_addr_z, ioctl_data_z, src_addr_z}, 0);

        // Back-pressure for 20 cycles after the 2nd write
        set_delays(1'b0);
        stray_en = 1'b0;
        base = wr_count;
        start_run();
        wait_writes(base + 2, "second");
        wait_force = 20;
        wait_done("wait20");

        // Random latency, random back-pressure, stray acks
        for (int r = 0; r < 4; r++) begin
            set_delays(1'b1);
            wait_rand = 1'b1;
            stray_en  = 1'b1;
            start_run();
            wait_done($sformatf("random%0d", r));
        end
        wait_rand = 1'b0;
        stray_en  = 1'b0;
        set_delays(1'b0);
        repeat (4) @(posedge clk50);
        #1;

        // Abort with rst_base during the 3rd gap
        base = wr_count;
        start_run();
        wait_writes(base + 3, "third");
        @(posedge clk50); #1;
        rst_base = 1'b1;
        exp_q.delete();
        exp_dl_fall  = -1;
        exp_done     = -1;
        chk_start_at = -1;
        repeat (2) @(posedge clk50);
        @(negedge clk50) rst_base = 1'b0;
        base = wr_count;
        repeat (30) @(posedge clk50);
        #1;
        chk("no_write_after_abort", wr_count, base);
        chk("idle_after_abort_dl_done_rst", {downloading, done, rst}, 3'b001);

        // Fresh download from address 0
        start_run();
        wait_done("after_abort");
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
